lane_runner_engine: RTL and testbench
=====================================

# lane_runner_engine

Parametrised game-state engine for the lane-dodging VGA game: owns the player slide, N falling obstacles across M lanes, scoring, collision and the start/play/gameover FSM. Replaces the hard-wired two-obstacle, three-lane logic that was previously embedded in the pixel colouriser. Outputs are registered screen-space coordinates (0-based, not hCount/vCount). A separate combinational renderer adds the VGA visible-area offsets and draws the sprites.

## Interface
- NUM_LANES, 3: lane count, 2..4
- NUM_OBS, 2: obstacle count, 1..8
- LANE_X0, 180: screen X of lane 0 centre
- LANE_PITCH, 140: X distance between lane centres
- OBJ_HALF_W, 40: half width of player and obstacle boxes
- OBJ_H, 80: height of player and obstacle boxes
- PLAYER_Y, 400: top Y of the player box
- SCREEN_H, 480: visible height
- OBS_STEP, 4: initial obstacle pixels per tick
- CAR_STEP, 5: player slide pixels per tick
- TICK_DIV, 4194304: clk cycles per game tick
- OBS_SPACING, 80: initial Y gap between consecutive obstacles
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- btn_l / btn_r / btn_c  in  1 each  debounced levels; the block edge-detects internally
- game_state  out  2  0 START, 1 PLAY, 2 GAMEOVER
- car_x  out  10  player centre X
- obs_y  out  10*NUM_OBS  packed obstacle top Y values; obstacle k occupies [10k+9:10k]
- obs_lane  out  2*NUM_OBS  packed obstacle lane indices
- score  out  16  obstacles passed, saturating
- collision  out  1  registered overlap flag
- tick  out  1  one-cycle game-tick strobe

## Operation
- **Reset.** Reset behaves like START entry.
  - game_state = START; lane = NUM_LANES/2; car_x = centre of that lane.
  - Obstacle k: y = k*OBS_SPACING, lane = k mod NUM_LANES.
  - score = 0, collision = 0, step = OBS_STEP, tick counter = 0.
  - LFSR = 8'hAC.
- **Lane centre.** LANE_X0 + lane*LANE_PITCH.
- **START.**
  - Positions are held at their reset values.
  - A btn_c rising edge moves the FSM to PLAY.
- **PLAY, car sub-FSM.**
  - READY:
    - A btn_l rising edge with lane>0 decrements lane and enters MOVING.
    - A btn_r rising edge with lane<NUM_LANES-1 increments lane and enters MOVING.
    - Rising edges on btn_l and btn_r in the same cycle are both ignored.
  - MOVING: on each tick, car_x steps CAR_STEP toward the target and is clamped to the target (no overshoot). When car_x equals the target, the sub-FSM returns to READY. Button edges are ignored while MOVING.
- **PLAY, obstacles.** On each tick, every obstacle is updated independently:
  - If y < SCREEN_H+OBJ_H, then y += step.
  - Otherwise y = 0, lane = LFSR slice [2k+1:2k mod 8] mod NUM_LANES, and the obstacle counts as passed.
  - score += number of obstacles that respawn in that tick. Simultaneous respawns each count, and score saturates at 16'hFFFF.
- **Collision.** Set when any obstacle box overlaps the player box.
  - Overlap condition: |car_x - obs_x| < 2*OBJ_HALF_W and obs_y < PLAYER_Y+OBJ_H and obs_y+OBJ_H > PLAYER_Y.
  - Evaluated on every cycle of PLAY using registered positions.
  - collision=1 moves the FSM to GAMEOVER.
- **PLAY exit on btn_c.** A btn_c rising edge returns to START. It has priority over a collision in the same cycle.
- **GAMEOVER.**
  - All positions and score are frozen; collision stays high.
  - A btn_c rising edge moves the FSM to START, which clears collision.
- **LFSR.** 8-bit, taps x^8+x^6+1. It free-runs every clk cycle in every state.
- **Arithmetic.** Y arithmetic is 11 bits internally so it cannot wrap; the outputs are truncated to 10 bits.

## Timing
- tick is asserted when the counter equals TICK_DIV-1; the counter then wraps to 0. The first tick comes TICK_DIV cycles after reset.
- Button edge to lane/state change: 1 cycle, counted from the cycle the sampled edge is visible.
- Position update to collision: 1 cycle. Collision to game_state=GAMEOVER: 1 cycle.
- All outputs are registered and change only on the clk rising edge.
- Reset mid-game returns to the reset values on the next edge, regardless of state or tick alignment.

## Configuration
- **LANE_RUNNER_SPEEDUP_EN defined.**
  - Every 8 points, step increments by 1, up to a ceiling of 3*OBS_STEP.
  - The check is on the score crossing a multiple of 8, so a multi-respawn tick that skips over a multiple still triggers.
  - step resets to OBS_STEP on START.
- **LANE_RUNNER_SPEEDUP_EN undefined.** step is constant at OBS_STEP.

## Structure
- Package lane_runner_pkg holds:
  - the game_state encoding (START/PLAY/GAMEOVER);
  - the car sub-state encoding;
  - the speedup interval (8) and multiplier (3).
- Sub-module lane_runner_lfsr: 8-bit LFSR with a parametrised seed, free-running, output [7:0].

## Test plan
- **Reset and start.** Use TICK_DIV=4. After reset, expect game_state=0, car_x=320, obs_y={80,0}, score=0. Pulse btn_c; game_state=1 after 1 cycle.
- **Slide clamp.** Use CAR_STEP=3. Press btn_l: car_x goes 320→317→…→182→180 on successive ticks, with no overshoot, then returns to READY. A second btn_l at lane 0 leaves lane unchanged.
- **Simultaneous respawn.** Use NUM_OBS=2 with OBS_SPACING=0. When both obstacles reach y=560 on the same tick, score increments by 2 and both y values become 0.
- **Collision.** Force an obstacle into the player's lane with y=324: collision=1 one cycle later, game_state=2 the cycle after. Positions stay frozen for 100 ticks.
- **btn_c priority.** Assert btn_c on the same cycle collision asserts: game_state goes to 0, not 2, and score clears.
- **Speedup.** With LANE_RUNNER_SPEEDUP_EN defined, reach score 8: Δy per tick goes 4→5. At score 64, step is 12 and stays 12.

Source files
------------

// File: rtl/lane_runner_pkg.sv
// ============================================================================
// Module      : lane_runner_pkg
// Description : Shared encodings and speedup constants for the lane runner.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lane_runner_pkg;

    localparam logic [1:0] c_ST_START    = 2'd0;
    localparam logic [1:0] c_ST_PLAY     = 2'd1;
    localparam logic [1:0] c_ST_GAMEOVER = 2'd2;

    localparam logic [0:0] c_CAR_READY  = 1'b0;
    localparam logic [0:0] c_CAR_MOVING = 1'b1;

    localparam int c_SPEEDUP_INTERVAL = 8;
    localparam int c_SPEEDUP_MULT     = 3;

endpackage

`default_nettype wire

// File: rtl/lane_runner_lfsr.sv
// ============================================================================
// Module      : lane_runner_lfsr
// Description : Free-running 8-bit Fibonacci LFSR, x^8 + x^6 + 1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_runner_lfsr #(
    parameter logic [7:0] SEED = 8'hAC
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] o_q
);

    logic [7:0] r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= SEED;
        end else begin
            r_q <= {r_q[6:0], r_q[7] ^ r_q[5]};
        end
    end

    assign o_q = r_q;

endmodule

`default_nettype wire

// File: rtl/lane_runner_engine.sv
// ============================================================================
// Module      : lane_runner_engine
// Description : Game-state engine: player slide, falling obstacles, scoring,
//               collision and START/PLAY/GAMEOVER control. Optional obstacle
//               speedup is enabled by defining LANE_RUNNER_SPEEDUP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_runner_engine
    import lane_runner_pkg::*;
#(
    parameter int NUM_LANES   = 3,
    parameter int NUM_OBS     = 2,
    parameter int LANE_X0     = 180,
    parameter int LANE_PITCH  = 140,
    parameter int OBJ_HALF_W  = 40,
    parameter int OBJ_H       = 80,
    parameter int PLAYER_Y    = 400,
    parameter int SCREEN_H    = 480,
    parameter int OBS_STEP    = 4,
    parameter int CAR_STEP    = 5,
    parameter int TICK_DIV    = 4194304,
    parameter int OBS_SPACING = 80
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   btn_l,
    input  logic                   btn_r,
    input  logic                   btn_c,
    output logic [1:0]             game_state,
    output logic [9:0]             car_x,
    output logic [10*NUM_OBS-1:0]  obs_y,
    output logic [2*NUM_OBS-1:0]   obs_lane,
    output logic [15:0]            score,
    output logic                   collision,
    output logic                   tick
);

`ifdef LANE_RUNNER_SPEEDUP_EN
    localparam bit c_SPEEDUP = 1'b1;
`else
    localparam bit c_SPEEDUP = 1'b0;
`endif

    localparam int          c_CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [10:0] c_Y_LIMIT  = 11'(SCREEN_H + OBJ_H);
    localparam logic [7:0]  c_STEP_MAX = 8'(c_SPEEDUP_MULT * OBS_STEP);

    function automatic logic [10:0] lane_x(input logic [1:0] lane);
        return 11'(LANE_X0 + int'(lane) * LANE_PITCH);
    endfunction

    function automatic logic [1:0] lane_wrap(input logic [7:0] v);
        return 2'(int'(v[1:0]) % NUM_LANES);
    endfunction

    function automatic logic obs_hits(input logic [10:0] y, input logic [1:0] lane,
                                      input logic [10:0] cx);
        int dx;
        dx = int'(cx) - int'(lane_x(lane));
        if (dx < 0) dx = -dx;
        return (dx < 2 * OBJ_HALF_W) && (int'(y) < PLAYER_Y + OBJ_H) &&
               (int'(y) + OBJ_H > PLAYER_Y);
    endfunction

    logic [1:0]          r_state;
    logic [0:0]          r_car_state;
    logic [1:0]          r_lane;
    logic [10:0]         r_car_x;
    logic [10:0]         r_obs_y    [NUM_OBS];
    logic [1:0]          r_obs_lane [NUM_OBS];
    logic [15:0]         r_score;
    logic                r_collision;
    logic [7:0]          r_step;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_tick;
    logic                r_btn_l_d, r_btn_r_d, r_btn_c_d;

    logic                w_rise_l, w_rise_r, w_rise_c, w_tick, w_overlap;
    logic [7:0]          w_lfsr;
    logic [10:0]         w_target, w_car_up, w_car_x_nx;
    logic [10:0]         w_obs_y_nx    [NUM_OBS];
    logic [1:0]          w_obs_lane_nx [NUM_OBS];
    logic [3:0]          w_respawns;
    logic [16:0]         w_score_sum;
    logic [15:0]         w_score_nx;
    logic [7:0]          w_step_nx;

    lane_runner_lfsr #(.SEED(8'hAC)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .o_q   (w_lfsr)
    );

    assign w_rise_l = btn_l & ~r_btn_l_d;
    assign w_rise_r = btn_r & ~r_btn_r_d;
    assign w_rise_c = btn_c & ~r_btn_c_d;
    assign w_tick   = (r_cnt == c_CNT_W'(TICK_DIV - 1));
    assign w_target = lane_x(r_lane);
    assign w_car_up = r_car_x + 11'(CAR_STEP);

    // Slide toward the target lane centre, clamping the final step
    always_comb begin
        w_car_x_nx = r_car_x;
        if (r_car_x < w_target) begin
            w_car_x_nx = (w_car_up >= w_target) ? w_target : w_car_up;
        end else if (r_car_x > w_target) begin
            w_car_x_nx = (r_car_x > w_target + 11'(CAR_STEP)) ? r_car_x - 11'(CAR_STEP)
                                                              : w_target;
        end
    end

    always_comb begin
        w_respawns = '0;
        w_overlap  = 1'b0;
        for (int k = 0; k < NUM_OBS; k++) begin
            w_obs_y_nx[k]    = r_obs_y[k] + 11'(r_step);
            w_obs_lane_nx[k] = r_obs_lane[k];
            if (r_obs_y[k] >= c_Y_LIMIT) begin
                w_obs_y_nx[k]    = '0;
                w_obs_lane_nx[k] = lane_wrap(w_lfsr >> ((2 * k) % 8));
                w_respawns       = w_respawns + 4'd1;
            end
            if (obs_hits(r_obs_y[k], r_obs_lane[k], r_car_x)) w_overlap = 1'b1;
        end
        w_score_sum = {1'b0, r_score} + 17'(w_respawns);
        w_score_nx  = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        // Crossing test rather than equality so multi-respawn ticks cannot skip a level
        w_step_nx   = r_step;
        if (c_SPEEDUP && (r_step < c_STEP_MAX) &&
            (int'(w_score_nx) / c_SPEEDUP_INTERVAL != int'(r_score) / c_SPEEDUP_INTERVAL)) begin
            w_step_nx = r_step + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        r_btn_l_d <= btn_l;
        r_btn_r_d <= btn_r;
        r_btn_c_d <= btn_c;
        if (reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_tick;
            r_cnt  <= w_tick ? '0 : r_cnt + c_CNT_W'(1);
        end

        // Reset, START hold and any btn_c exit share one START-entry load
        if (reset || w_rise_c || (r_state != c_ST_PLAY && r_state != c_ST_GAMEOVER)) begin
            r_state     <= (!reset && r_state == c_ST_START && w_rise_c) ? c_ST_PLAY : c_ST_START;
            r_car_state <= c_CAR_READY;
            r_lane      <= 2'(NUM_LANES / 2);
            r_car_x     <= lane_x(2'(NUM_LANES / 2));
            for (int k = 0; k < NUM_OBS; k++) begin
                r_obs_y[k]    <= 11'(k * OBS_SPACING);
                r_obs_lane[k] <= 2'(k % NUM_LANES);
            end
            r_score     <= '0;
            r_collision <= 1'b0;
            r_step      <= 8'(OBS_STEP);
        end else if (r_state == c_ST_PLAY) begin
            r_collision <= w_overlap;
            if (r_collision) r_state <= c_ST_GAMEOVER;
            if (w_tick) begin
                for (int k = 0; k < NUM_OBS; k++) begin
                    r_obs_y[k]    <= w_obs_y_nx[k];
                    r_obs_lane[k] <= w_obs_lane_nx[k];
                end
                r_score <= w_score_nx;
                r_step  <= w_step_nx;
            end
            if (r_car_state == c_CAR_READY) begin
                if (w_rise_l && !w_rise_r && r_lane != 2'd0) begin
                    r_lane      <= r_lane - 2'd1;
                    r_car_state <= c_CAR_MOVING;
                end else if (w_rise_r && !w_rise_l && r_lane < 2'(NUM_LANES - 1)) begin
                    r_lane      <= r_lane + 2'd1;
                    r_car_state <= c_CAR_MOVING;
                end
            end else if (w_tick) begin
                r_car_x <= w_car_x_nx;
                if (w_car_x_nx == w_target) r_car_state <= c_CAR_READY;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_OBS; g++) begin : g_pack
            assign obs_y[10*g +: 10]  = r_obs_y[g][9:0];
            assign obs_lane[2*g +: 2] = r_obs_lane[g];
        end
    endgenerate

    assign game_state = r_state;
    assign car_x      = r_car_x[9:0];
    assign score      = r_score;
    assign collision  = r_collision;
    assign tick       = r_tick;

endmodule

`default_nettype wire

// File: tb/tb_lane_runner_engine.sv
// ============================================================================
// Module      : tb_lane_runner_engine
// Description : Self-checking bench for lane_runner_engine (three configurations).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lane_runner_engine;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // A: slide/collision config, B: simultaneous respawn, C: no-collision speedup run
    logic a_l = 0, a_r = 0, a_c = 0, b_l = 0, b_r = 0, b_c = 0, c_l = 0, c_r = 0, c_c = 0;
    logic [1:0]  a_state, b_state, c_state;
    logic [9:0]  a_car_x, b_car_x, c_car_x;
    logic [19:0] a_obs_y, b_obs_y;
    logic [79:0] c_obs_y;
    logic [3:0]  a_obs_lane, b_obs_lane;
    logic [15:0] c_obs_lane;
    logic [15:0] a_score, b_score, c_score;
    logic        a_coll, b_coll, c_coll, a_tick, b_tick, c_tick;

    int n_vec = 0;
    int n_bad = 0;
    int exp_q[$];

    lane_runner_engine #(.TICK_DIV(4), .CAR_STEP(3)) u_a (
        .clk(clk), .reset(reset), .btn_l(a_l), .btn_r(a_r), .btn_c(a_c),
        .game_state(a_state), .car_x(a_car_x), .obs_y(a_obs_y), .obs_lane(a_obs_lane),
        .score(a_score), .collision(a_coll), .tick(a_tick));

    lane_runner_engine #(.TICK_DIV(4), .OBS_SPACING(0)) u_b (
        .clk(clk), .reset(reset), .btn_l(b_l), .btn_r(b_r), .btn_c(b_c),
        .game_state(b_state), .car_x(b_car_x), .obs_y(b_obs_y), .obs_lane(b_obs_lane),
        .score(b_score), .collision(b_coll), .tick(b_tick));

    lane_runner_engine #(.TICK_DIV(2), .NUM_OBS(8), .OBS_SPACING(0), .PLAYER_Y(900)) u_c (
        .clk(clk), .reset(reset), .btn_l(c_l), .btn_r(c_r), .btn_c(c_c),
        .game_state(c_state), .car_x(c_car_x), .obs_y(c_obs_y), .obs_lane(c_obs_lane),
        .score(c_score), .collision(c_coll), .tick(c_tick));

    task automatic set_btn(input int which, input logic l, input logic r, input logic c);
        case (which)
            0:       begin a_l = l; a_r = r; a_c = c; end
            1:       begin b_l = l; b_r = r; b_c = c; end
            default: begin c_l = l; c_r = r; c_c = c; end
        endcase
    endtask

    task automatic pulse(input int which, input logic l, input logic r, input logic c);
        @(negedge clk);
        set_btn(which, l, r, c);
        @(negedge clk);
        set_btn(which, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic wait_tick(input int which);
        int  n = 0;
        logic t;
        do begin
            @(negedge clk);
            n++;
            t = (which == 0) ? a_tick : (which == 1) ? b_tick : c_tick;
        end while (!t && n < 64);
        if (!t) begin
            n_vec++; n_bad++;
            $display("FAIL tick_timeout inst %0d: no tick after %0d cycles, need within 64", which, n);
        end
    endtask

    task automatic test_reset();
        int n = 0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_vec++; if (a_state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d need 0", a_state); end
        n_vec++; if (a_car_x !== 10'd320) begin n_bad++; $display("FAIL reset_car_x: got %0d need 320", a_car_x); end
        n_vec++; if (a_obs_y !== {10'd80, 10'd0}) begin n_bad++; $display("FAIL reset_obs_y: got %h need %h", a_obs_y, {10'd80, 10'd0}); end
        n_vec++; if (a_obs_lane !== 4'b0100) begin n_bad++; $display("FAIL reset_obs_lane: got %b need 0100", a_obs_lane); end
        n_vec++; if (a_score !== 16'd0) begin n_bad++; $display("FAIL reset_score: got %0d need 0", a_score); end
        n_vec++; if (a_coll !== 1'b0) begin n_bad++; $display("FAIL reset_collision: got %0d need 0", a_coll); end
        n_vec++; if (b_obs_y !== 20'd0) begin n_bad++; $display("FAIL reset_b_obs_y: got %h need 0", b_obs_y); end
        do begin @(negedge clk); n++; end while (!a_tick && n < 50);
        n_vec++; if (n != 4) begin n_bad++; $display("FAIL first_tick: got %0d cycles need 4", n); end
        n_vec++; if (a_obs_y !== {10'd80, 10'd0}) begin n_bad++; $display("FAIL start_hold: got %h need %h", a_obs_y, {10'd80, 10'd0}); end
    endtask

    task automatic test_start();
        pulse(0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (a_state !== 2'd1) begin n_bad++; $display("FAIL start_to_play: got %0d need 1", a_state); end
    endtask

    task automatic test_slide();
        int e;
        for (int v = 317; v > 180; v -= 3) exp_q.push_back(v);
        exp_q.push_back(180);
        pulse(0, 1'b1, 1'b0, 1'b0);
        while (exp_q.size() > 0) begin
            wait_tick(0);
            e = exp_q.pop_front();
            n_vec++; if (a_car_x !== 10'(e)) begin n_bad++; $display("FAIL slide_car_x: got %0d need %0d", a_car_x, e); end
        end
        pulse(0, 1'b1, 1'b0, 1'b0);
        repeat (3) wait_tick(0);
        n_vec++; if (a_car_x !== 10'd180) begin n_bad++; $display("FAIL left_at_lane0: got %0d need 180", a_car_x); end
        pulse(0, 1'b1, 1'b1, 1'b0);
        repeat (2) wait_tick(0);
        n_vec++; if (a_car_x !== 10'd180) begin n_bad++; $display("FAIL both_buttons: got %0d need 180", a_car_x); end
    endtask

    task automatic test_collision();
        int n = 0;
        pulse(0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (a_state !== 2'd0) begin n_bad++; $display("FAIL play_exit: got %0d need 0", a_state); end
        n_vec++; if (a_car_x !== 10'd320) begin n_bad++; $display("FAIL exit_car_x: got %0d need 320", a_car_x); end
        n_vec++; if (a_obs_y !== {10'd80, 10'd0}) begin n_bad++; $display("FAIL exit_obs_y: got %h need %h", a_obs_y, {10'd80, 10'd0}); end
        pulse(0, 1'b0, 1'b0, 1'b1);
        while (!a_coll && n < 2000) begin @(negedge clk); n++; end
        n_vec++; if (a_coll !== 1'b1) begin n_bad++; $display("FAIL collision_seen: got %0d need 1", a_coll); end
        n_vec++; if (a_obs_y !== {10'd324, 10'd244}) begin n_bad++; $display("FAIL collision_obs_y: got %h need %h", a_obs_y, {10'd324, 10'd244}); end
        n_vec++; if (a_state !== 2'd1) begin n_bad++; $display("FAIL collision_state_lag: got %0d need 1", a_state); end
        @(negedge clk);
        n_vec++; if (a_state !== 2'd2) begin n_bad++; $display("FAIL gameover_state: got %0d need 2", a_state); end
        repeat (100) wait_tick(0);
        n_vec++; if (a_obs_y !== {10'd324, 10'd244}) begin n_bad++; $display("FAIL frozen_obs_y: got %h need %h", a_obs_y, {10'd324, 10'd244}); end
        n_vec++; if (a_car_x !== 10'd320) begin n_bad++; $display("FAIL frozen_car_x: got %0d need 320", a_car_x); end
        n_vec++; if (a_coll !== 1'b1 || a_state !== 2'd2) begin n_bad++; $display("FAIL frozen_flags: got coll %0d state %0d need 1 2", a_coll, a_state); end
        pulse(0, 1'b0, 1'b0, 1'b1);
        n_vec++; if (a_state !== 2'd0 || a_coll !== 1'b0) begin n_bad++; $display("FAIL gameover_exit: got state %0d coll %0d need 0 0", a_state, a_coll); end
    endtask

    task automatic test_respawn();
        int y = 0, sc = 0, e;
        pulse(1, 1'b0, 1'b0, 1'b1);
        for (int t = 1; t <= 141; t++) begin
            if (y < 560) y += 4; else begin y = 0; sc += 2; end
            exp_q.push_back((sc << 16) | y);
            if (t == 1) b_r = 1'b1;
            wait_tick(1);
            b_r = 1'b0;
            e = exp_q.pop_front();
            n_vec++; if (b_obs_y !== {10'(e & 16'hFFFF), 10'(e & 16'hFFFF)}) begin n_bad++; $display("FAIL respawn_y t%0d: got %h need %0d", t, b_obs_y, e & 16'hFFFF); end
            n_vec++; if (b_score !== 16'(e >> 16)) begin n_bad++; $display("FAIL respawn_score t%0d: got %0d need %0d", t, b_score, e >> 16); end
        end
        n_vec++; if (b_obs_lane[1:0] > 2'd2 || b_obs_lane[3:2] > 2'd2) begin n_bad++; $display("FAIL respawn_lane: got %b need each < 3", b_obs_lane); end
        n_vec++; if (b_car_x !== 10'd460) begin n_bad++; $display("FAIL right_slide: got %0d need 460", b_car_x); end
    endtask

    task automatic test_btn_c_priority();
        int tgt, cur, n;
        tgt = int'(b_obs_lane[1:0]);
        cur = 2;
        while (cur > tgt) begin
            pulse(1, 1'b1, 1'b0, 1'b0);
            cur--;
            n = 0;
            while (b_car_x !== 10'(180 + cur * 140) && n < 1000) begin @(negedge clk); n++; end
            if (n >= 1000) begin n_vec++; n_bad++; $display("FAIL steer_timeout: got %0d need %0d", b_car_x, 180 + cur * 140); end
        end
        n = 0;
        while (!b_coll && n < 2000) begin @(negedge clk); n++; end
        b_c = 1'b1;
        n_vec++; if (b_coll !== 1'b1) begin n_bad++; $display("FAIL prio_collision: got %0d need 1", b_coll); end
        n_vec++; if (b_obs_y[9:0] !== 10'd324) begin n_bad++; $display("FAIL prio_obs_y: got %0d need 324", b_obs_y[9:0]); end
        n_vec++; if (b_score !== 16'd2) begin n_bad++; $display("FAIL prio_score_before: got %0d need 2", b_score); end
        @(negedge clk);
        b_c = 1'b0;
        n_vec++; if (b_state !== 2'd0) begin n_bad++; $display("FAIL prio_state: got %0d need 0", b_state); end
        n_vec++; if (b_score !== 16'd0 || b_coll !== 1'b0) begin n_bad++; $display("FAIL prio_clear: got score %0d coll %0d need 0 0", b_score, b_coll); end
    endtask

    task automatic test_speedup();
        int y = 0, step = 4, sc = 0, nsc, e, t = 0;
        pulse(2, 1'b0, 1'b0, 1'b1);
        while (sc < 80 && t < 3000) begin
            t++;
            if (y < 560) y += step;
            else begin
                y = 0;
                nsc = (sc + 8 > 65535) ? 65535 : sc + 8;
`ifdef LANE_RUNNER_SPEEDUP_EN
                if ((nsc / 8 != sc / 8) && step < 12) step++;
`endif
                sc = nsc;
            end
            exp_q.push_back((sc << 16) | y);
            wait_tick(2);
            e = exp_q.pop_front();
            n_vec++; if (c_obs_y[9:0] !== 10'(e & 16'hFFFF) || c_obs_y[79:70] !== 10'(e & 16'hFFFF)) begin
                n_bad++; $display("FAIL speed_y t%0d: got %0d/%0d need %0d", t, c_obs_y[9:0], c_obs_y[79:70], e & 16'hFFFF); end
            n_vec++; if (c_score !== 16'(e >> 16)) begin n_bad++; $display("FAIL speed_score t%0d: got %0d need %0d", t, c_score, e >> 16); end
        end
        n_vec++; if (c_coll !== 1'b0 || c_state !== 2'd1) begin n_bad++; $display("FAIL speed_state: got coll %0d state %0d need 0 1", c_coll, c_state); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_start();
        test_slide();
        test_collision();
        test_respawn();
        test_btn_c_priority();
        test_speedup();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
